multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control unit for the multicycle RV32I core, replacing the single-cycle main decoder.
- A Moore FSM sequences each instruction over 3–5 cycles through one shared ALU and one unified instruction/data memory.
- Adds an optional memory-ready handshake, bne support, a sticky custom HALT state and an illegal-opcode trap.
- The existing ALU decoder consumes ALUOp unchanged.

Parameters:
- MEM_HANDSHAKE, 0: 1 makes FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0 treats memory as always ready.
- HALT_OPCODE, 7'b1000100: custom opcode that halts the core.
- TRAP_ON_ILLEGAL, 1: 1 makes an unknown opcode enter sticky TRAP; 0 executes it as a NOP.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- op  in  7  instr[6:0] from the instruction register
- funct3_0  in  1  instr[12]; 0 = beq, 1 = bne
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle (ignored when MEM_HANDSHAKE=0)
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register and OldPC enable
- mem_req  out  1  memory access in progress
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = constant 4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- ALUOp  out  2  to the ALU decoder
- RegWrite  out  1  register file write enable
- retire  out  1  one-cycle pulse in an instruction's final cycle
- halted  out  1  in HALT
- illegal  out  1  in TRAP
- state_dbg  out  4  current state encoding

Behaviour:
- Reset:
  - reset low forces state to FETCH asynchronously.
  - While reset is low, PCWrite, IRWrite, MemWrite, RegWrite, retire and mem_req are forced to 0.
  - All other outputs take their FETCH values.
  - Reset asserted mid-instruction aborts it with no partial write after assertion.
- Outputs: all are Moore functions of state, except:
  - ImmSrc: combinational from op.
  - PCWrite = PCUpdate | (Branch & (zero ^ funct3_0)).
  - Handshake gating, below.
- Unlisted control signals are 0 in each state.
- State encoding and outputs:
  - FETCH(0): AdrSrc=0, mem_req=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCUpdate=1 only in the completing cycle. -> DECODE.
  - DECODE(1): ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Transitions by op:
    - lw/sw -> MEMADR
    - R-type -> EXECR
    - I-ALU -> EXECI
    - B -> BRANCH
    - jal -> JAL
    - jalr -> JALR
    - HALT_OPCODE -> HALT
    - other -> TRAP if TRAP_ON_ILLEGAL, else FETCH (no writes, retire=1)
  - MEMADR(2): ALUSrcA=10, ALUSrcB=01, ALUOp=00. -> MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD(3): AdrSrc=1, mem_req=1. Waits for completion, then -> MEMWB.
  - MEMWB(4): ResultSrc=01, RegWrite=1, retire=1. -> FETCH.
  - MEMWRITE(5): AdrSrc=1, mem_req=1, MemWrite=1 held until completion; retire=1 in the completing cycle. -> FETCH after completion.
  - EXECR(6): ALUSrcA=10, ALUSrcB=00, ALUOp=10. -> ALUWB.
  - EXECI(7): ALUSrcA=10, ALUSrcB=01, ALUOp=10. -> ALUWB.
  - ALUWB(8): ResultSrc=00, RegWrite=1, retire=1. -> FETCH.
  - BRANCH(9): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, retire=1. -> FETCH.
  - JAL(10): ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. -> ALUWB.
  - JALR(11): ALUSrcA=10, ALUSrcB=01, ALUOp=00, ResultSrc=10, PCUpdate=1. -> JALRLINK.
  - JALRLINK(12): ALUSrcA=01, ALUSrcB=10, ALUOp=00. -> ALUWB.
  - HALT(13): halted=1. Sticky; exits only on reset.
  - TRAP(14): illegal=1. Sticky; exits only on reset.
  - Encoding 15 is unused and recovers to FETCH next cycle.
- Latency (MEM_HANDSHAKE=0), in cycles:
  - branch: 3
  - R / I-ALU / sw / jal: 4
  - lw / jalr: 5
- Handshake (MEM_HANDSHAKE=1):
  - Completion means mem_ready=1 in a memory state; each wait cycle adds one cycle.
  - Address select, mem_req and MemWrite stay stable while waiting.
  - PCWrite and IRWrite pulse exactly once per fetch.
  - mem_ready outside memory states is ignored.
  - mem_ready high on the first cycle of a memory state gives zero wait.
- PCWrite is never asserted twice for one instruction.
- RegWrite is never asserted for sw, branch, HALT or TRAP.

Decomposition:
- Package multicycle_ctrl_pkg:
  - state encodings
  - RV32I opcode constants (LW, SW, RTYPE, ITYPE, BTYPE, JAL, JALR)
  - ALUSrcA/ALUSrcB/ResultSrc/ImmSrc/ALUOp encodings
- Sub-module immsrc_dec: combinational op -> ImmSrc.
  - lw/jalr/I-ALU -> 00, sw -> 01, B -> 10, jal -> 11, others -> 00.

Test Plan:
1. op=0110011, MEM_HANDSHAKE=0, 2 instrs back-to-back -> states 0,1,6,8,0,1,6,8; RegWrite only in state 8; retire pulses at cycles 4 and 8.
2. op=1100011, funct3_0=1, zero=0 then zero=1 -> PCWrite=1 in BRANCH for the first, 0 for the second; each instruction takes 3 cycles; no RegWrite.
3. MEM_HANDSHAKE=1, lw with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD -> 10 total cycles; IRWrite/PCWrite pulse once; AdrSrc=1 stable throughout MEMREAD.
4. sw with mem_ready delayed 2 cycles -> MemWrite high for 3 cycles, retire in the last; jalr -> JALR with ResultSrc=10, PCWrite=1, then JALRLINK, ALUWB with RegWrite=1.
5. op=1000100 -> HALT; halted=1 held for 100 cycles with no enables; reset low -> FETCH with all enables 0; release -> normal fetch.
6. op=1111111 with TRAP_ON_ILLEGAL=1 -> TRAP, illegal=1 sticky; with TRAP_ON_ILLEGAL=0 -> back to FETCH after DECODE, retire=1, no writes; reset asserted in MEMWRITE -> MemWrite drops immediately.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit: state encodings,
// opcode constants, datapath mux encodings and the per-state control bundle.
package multicycle_ctrl_pkg;

   // FSM state encodings (visible on state_dbg)
   localparam logic [3:0] ST_FETCH    = 4'd0;
   localparam logic [3:0] ST_DECODE   = 4'd1;
   localparam logic [3:0] ST_MEMADR   = 4'd2;
   localparam logic [3:0] ST_MEMREAD  = 4'd3;
   localparam logic [3:0] ST_MEMWB    = 4'd4;
   localparam logic [3:0] ST_MEMWRITE = 4'd5;
   localparam logic [3:0] ST_EXECR    = 4'd6;
   localparam logic [3:0] ST_EXECI    = 4'd7;
   localparam logic [3:0] ST_ALUWB    = 4'd8;
   localparam logic [3:0] ST_BRANCH   = 4'd9;
   localparam logic [3:0] ST_JAL      = 4'd10;
   localparam logic [3:0] ST_JALR     = 4'd11;
   localparam logic [3:0] ST_JALRLINK = 4'd12;
   localparam logic [3:0] ST_HALT     = 4'd13;
   localparam logic [3:0] ST_TRAP     = 4'd14;

   // RV32I opcodes handled by the core
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BTYPE = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   // ALU operand A select
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALU operand B select
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result bus select
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // Immediate format select
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // ALUOp to the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Moore control bundle produced from the current state
   typedef struct packed {
      logic       pcUpdate;
      logic       branch;
      logic       adrSrc;
      logic       memWrite;
      logic       irWrite;
      logic       memReq;
      logic [1:0] resultSrc;
      logic [1:0] aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic       regWrite;
      logic       retire;
      logic       halted;
      logic       illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

   // True for the standard RV32I opcodes this core executes
   function automatic logic isStdOpcode(input logic [6:0] opc);
      isStdOpcode = (opc == OP_LW)    || (opc == OP_SW)    ||
                    (opc == OP_RTYPE) || (opc == OP_ITYPE) ||
                    (opc == OP_BTYPE) || (opc == OP_JAL)   ||
                    (opc == OP_JALR);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_immsrc_dec.sv
// Immediate format decoder: picks the immediate layout straight from the opcode.
module immsrc_dec
   import multicycle_ctrl_pkg::*;
(
   input  logic [6:0] op,
   output logic [1:0] immSrc
);

   // Opcode to immediate format; anything unrecognised uses the I layout
   always_comb begin
      immSrc = IMM_I;
      case (op)
         OP_LW, OP_JALR, OP_ITYPE: immSrc = IMM_I;
         OP_SW:                    immSrc = IMM_S;
         OP_BTYPE:                 immSrc = IMM_B;
         OP_JAL:                   immSrc = IMM_J;
         default:                  immSrc = IMM_I;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core. One Moore state per
// instruction phase drives the shared ALU and the unified memory; HALT and
// TRAP are sticky until reset.
//
// Memory handshake: mem_req acts as valid. While it is high, AdrSrc and
// MemWrite hold steady; the access completes in the first cycle mem_ready is
// seen high (including the very first cycle). With MEM_HANDSHAKE=0 every
// mem_req cycle completes and mem_ready is ignored. mem_ready outside a
// memory state has no effect.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter bit         MEM_HANDSHAKE   = 1'b0,
   parameter logic [6:0] HALT_OPCODE     = 7'b1000100,
   parameter bit         TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       funct3_0,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       mem_req,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [1:0] ALUOp,
   output logic       RegWrite,
   output logic       retire,
   output logic       halted,
   output logic       illegal,
   output logic [3:0] state_dbg
);

   logic [3:0] state;
   logic [3:0] nextState;
   ctrl_t      ctrl;
   logic       memDone;
   logic       opKnown;
   logic       branchTaken;

   // A memory access finishes this cycle when ready (or always, without handshake)
   assign memDone = MEM_HANDSHAKE ? mem_ready : 1'b1;

   // Opcodes that have a defined sequence, including the custom halt
   assign opKnown = isStdOpcode(op) || (op == HALT_OPCODE);

   // beq takes on zero, bne on non-zero
   assign branchTaken = zero ^ funct3_0;

   // State register; reset returns to FETCH immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_FETCH;
      end else begin
         state <= nextState;
      end
   end

   // Next-state selection
   always_comb begin
      nextState = ST_FETCH;
      case (state)
         ST_FETCH:    nextState = memDone ? ST_DECODE : ST_FETCH;
         ST_DECODE: begin
            case (op)
               OP_LW, OP_SW: nextState = ST_MEMADR;
               OP_RTYPE:     nextState = ST_EXECR;
               OP_ITYPE:     nextState = ST_EXECI;
               OP_BTYPE:     nextState = ST_BRANCH;
               OP_JAL:       nextState = ST_JAL;
               OP_JALR:      nextState = ST_JALR;
               default: begin
                  if (op == HALT_OPCODE) begin
                     nextState = ST_HALT;
                  end else if (TRAP_ON_ILLEGAL) begin
                     nextState = ST_TRAP;
                  end else begin
                     nextState = ST_FETCH;
                  end
               end
            endcase
         end
         ST_MEMADR:   nextState = (op == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
         ST_MEMREAD:  nextState = memDone ? ST_MEMWB : ST_MEMREAD;
         ST_MEMWB:    nextState = ST_FETCH;
         ST_MEMWRITE: nextState = memDone ? ST_FETCH : ST_MEMWRITE;
         ST_EXECR:    nextState = ST_ALUWB;
         ST_EXECI:    nextState = ST_ALUWB;
         ST_ALUWB:    nextState = ST_FETCH;
         ST_BRANCH:   nextState = ST_FETCH;
         ST_JAL:      nextState = ST_ALUWB;
         ST_JALR:     nextState = ST_JALRLINK;
         ST_JALRLINK: nextState = ST_ALUWB;
         ST_HALT:     nextState = ST_HALT;
         ST_TRAP:     nextState = ST_TRAP;
         default:     nextState = ST_FETCH;
      endcase
   end

   // Per-state control values; only the completing-cycle strobes look at memDone
   always_comb begin
      ctrl = CTRL_IDLE;
      case (state)
         ST_FETCH: begin
            ctrl.memReq    = 1'b1;
            ctrl.adrSrc    = 1'b0;
            ctrl.aluSrcA   = SRCA_PC;
            ctrl.aluSrcB   = SRCB_FOUR;
            ctrl.aluOp     = ALUOP_ADD;
            ctrl.resultSrc = RES_ALURESULT;
            ctrl.irWrite   = memDone;
            ctrl.pcUpdate  = memDone;
         end
         ST_DECODE: begin
            ctrl.aluSrcA = SRCA_OLDPC;
            ctrl.aluSrcB = SRCB_IMM;
            ctrl.aluOp   = ALUOP_ADD;
            // an unknown opcode run as a NOP finishes here
            ctrl.retire  = !opKnown && !TRAP_ON_ILLEGAL;
         end
         ST_MEMADR: begin
            ctrl.aluSrcA = SRCA_RS1;
            ctrl.aluSrcB = SRCB_IMM;
            ctrl.aluOp   = ALUOP_ADD;
         end
         ST_MEMREAD: begin
            ctrl.adrSrc = 1'b1;
            ctrl.memReq = 1'b1;
         end
         ST_MEMWB: begin
            ctrl.resultSrc = RES_DATA;
            ctrl.regWrite  = 1'b1;
            ctrl.retire    = 1'b1;
         end
         ST_MEMWRITE: begin
            ctrl.adrSrc   = 1'b1;
            ctrl.memReq   = 1'b1;
            ctrl.memWrite = 1'b1;
            ctrl.retire   = memDone;
         end
         ST_EXECR: begin
            ctrl.aluSrcA = SRCA_RS1;
            ctrl.aluSrcB = SRCB_RS2;
            ctrl.aluOp   = ALUOP_FUNCT;
         end
         ST_EXECI: begin
            ctrl.aluSrcA = SRCA_RS1;
            ctrl.aluSrcB = SRCB_IMM;
            ctrl.aluOp   = ALUOP_FUNCT;
         end
         ST_ALUWB: begin
            ctrl.resultSrc = RES_ALUOUT;
            ctrl.regWrite  = 1'b1;
            ctrl.retire    = 1'b1;
         end
         ST_BRANCH: begin
            ctrl.aluSrcA   = SRCA_RS1;
            ctrl.aluSrcB   = SRCB_RS2;
            ctrl.aluOp     = ALUOP_SUB;
            ctrl.resultSrc = RES_ALUOUT;
            ctrl.branch    = 1'b1;
            ctrl.retire    = 1'b1;
         end
         ST_JAL: begin
            // PC takes the target computed in DECODE; ALU forms the link
            ctrl.aluSrcA   = SRCA_OLDPC;
            ctrl.aluSrcB   = SRCB_FOUR;
            ctrl.aluOp     = ALUOP_ADD;
            ctrl.resultSrc = RES_ALUOUT;
            ctrl.pcUpdate  = 1'b1;
         end
         ST_JALR: begin
            // target rs1+imm goes straight to the PC from the ALU result
            ctrl.aluSrcA   = SRCA_RS1;
            ctrl.aluSrcB   = SRCB_IMM;
            ctrl.aluOp     = ALUOP_ADD;
            ctrl.resultSrc = RES_ALURESULT;
            ctrl.pcUpdate  = 1'b1;
         end
         ST_JALRLINK: begin
            ctrl.aluSrcA = SRCA_OLDPC;
            ctrl.aluSrcB = SRCB_FOUR;
            ctrl.aluOp   = ALUOP_ADD;
         end
         ST_HALT:  ctrl.halted  = 1'b1;
         ST_TRAP:  ctrl.illegal = 1'b1;
         default:  ctrl = CTRL_IDLE;
      endcase
   end

   immsrc_dec uImmSrc (
      .op     (op),
      .immSrc (ImmSrc)
   );

   // Write enables and strobes are suppressed while reset is held low
   assign PCWrite   = reset & (ctrl.pcUpdate | (ctrl.branch & branchTaken));
   assign IRWrite   = reset & ctrl.irWrite;
   assign MemWrite  = reset & ctrl.memWrite;
   assign RegWrite  = reset & ctrl.regWrite;
   assign retire    = reset & ctrl.retire;
   assign mem_req   = reset & ctrl.memReq;
   assign AdrSrc    = ctrl.adrSrc;
   assign ResultSrc = ctrl.resultSrc;
   assign ALUSrcA   = ctrl.aluSrcA;
   assign ALUSrcB   = ctrl.aluSrcB;
   assign ALUOp     = ctrl.aluOp;
   assign halted    = ctrl.halted;
   assign illegal   = ctrl.illegal;
   assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two instances (handshake+trap, and no-handshake
// with illegal-as-NOP). Each instruction is expanded into the cycle-by-cycle
// output sequence the control unit must produce, and that queue is replayed
// against the selected instance.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       resetA, resetB;
   logic [6:0] op;
   logic       funct3_0, zero, mem_ready;
   wire [22:0] outA, outB;
   bit         sel;
   string      tag;
   int         cmp_cnt = 0;
   int         err_cnt = 0;

   // {op, funct3_0, zero, mem_ready, expected outputs}
   logic [32:0] exp_q[$];
   logic [6:0]  g_op;
   logic        g_f3, g_z;
   logic [6:0]  legal_ops[7];

   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .HALT_OPCODE(7'b1000100), .TRAP_ON_ILLEGAL(1'b1)) dutA (
      .clk(clk), .reset(resetA), .op(op), .funct3_0(funct3_0), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(outA[18]), .AdrSrc(outA[17]), .MemWrite(outA[16]), .IRWrite(outA[15]), .mem_req(outA[14]),
      .ResultSrc(outA[13:12]), .ALUSrcA(outA[11:10]), .ALUSrcB(outA[9:8]), .ImmSrc(outA[7:6]),
      .ALUOp(outA[5:4]), .RegWrite(outA[3]), .retire(outA[2]), .halted(outA[1]), .illegal(outA[0]),
      .state_dbg(outA[22:19]));

   multicycle_ctrl #(.MEM_HANDSHAKE(1'b0), .HALT_OPCODE(7'b1000100), .TRAP_ON_ILLEGAL(1'b0)) dutB (
      .clk(clk), .reset(resetB), .op(op), .funct3_0(funct3_0), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(outB[18]), .AdrSrc(outB[17]), .MemWrite(outB[16]), .IRWrite(outB[15]), .mem_req(outB[14]),
      .ResultSrc(outB[13:12]), .ALUSrcA(outB[11:10]), .ALUSrcB(outB[9:8]), .ImmSrc(outB[7:6]),
      .ALUOp(outB[5:4]), .RegWrite(outB[3]), .retire(outB[2]), .halted(outB[1]), .illegal(outB[0]),
      .state_dbg(outB[22:19]));

   function automatic logic [1:0] imm_of(input logic [6:0] o);
      case (o)
         7'b0000011, 7'b1100111, 7'b0010011: imm_of = 2'b00;
         7'b0100011: imm_of = 2'b01;
         7'b1100011: imm_of = 2'b10;
         7'b1101111: imm_of = 2'b11;
         default:    imm_of = 2'b00;
      endcase
   endfunction

   function automatic bit is_legal(input logic [6:0] o);
      is_legal = 1'b0;
      for (int i = 0; i < 7; i++) if (legal_ops[i] == o) is_legal = 1'b1;
      if (o == 7'b1000100) is_legal = 1'b1;
   endfunction

   // Expected output word for one cycle
   function automatic logic [22:0] mk(input logic [3:0] st, input logic pcw, adr, mw, irw, mreq,
                                      input logic [1:0] rs, a, b, alu,
                                      input logic rw, ret, hlt, ill);
      mk = {st, pcw, adr, mw, irw, mreq, rs, a, b, imm_of(g_op), alu, rw, ret, hlt, ill};
   endfunction

   // mem_ready for a cycle: handshaking DUT sees 0 while waiting, 1 on completion;
   // otherwise it is random and must make no difference
   function automatic logic mrv(input bit hs, input bit complete);
      mrv = hs ? complete : 1'($urandom_range(0, 1));
   endfunction

   function automatic logic rnd();
      rnd = 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic mr, input logic [22:0] e);
      exp_q.push_back({g_op, g_f3, g_z, mr, e});
   endtask

   // Expand one instruction into its expected cycle sequence
   task automatic gen_instr(input logic [6:0] o, input logic f3, z, input int wf, wm,
                            input bit hs, trap, input int stick);
      g_op = o; g_f3 = f3; g_z = z;
      for (int i = 0; i < wf; i++) push(mrv(hs, 0), mk(0, 0,0,0,0,1, 2'b10,2'b00,2'b10,2'b00, 0,0,0,0));
      push(mrv(hs, 1), mk(0, 1,0,0,1,1, 2'b10,2'b00,2'b10,2'b00, 0,0,0,0));
      push(rnd(), mk(1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 0, !is_legal(o) && !trap, 0,0));
      case (o)
         7'b0000011: begin
            push(rnd(), mk(2, 0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 0,0,0,0));
            for (int i = 0; i < wm; i++) push(mrv(hs, 0), mk(3, 0,1,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0));
            push(mrv(hs, 1), mk(3, 0,1,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0));
            push(rnd(), mk(4, 0,0,0,0,0, 2'b01,2'b00,2'b00,2'b00, 1,1,0,0));
         end
         7'b0100011: begin
            push(rnd(), mk(2, 0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 0,0,0,0));
            for (int i = 0; i < wm; i++) push(mrv(hs, 0), mk(5, 0,1,1,0,1, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0));
            push(mrv(hs, 1), mk(5, 0,1,1,0,1, 2'b00,2'b00,2'b00,2'b00, 0,1,0,0));
         end
         7'b0110011: begin
            push(rnd(), mk(6, 0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0,0,0,0));
            push(rnd(), mk(8, 0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,1,0,0));
         end
         7'b0010011: begin
            push(rnd(), mk(7, 0,0,0,0,0, 2'b00,2'b10,2'b01,2'b10, 0,0,0,0));
            push(rnd(), mk(8, 0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,1,0,0));
         end
         7'b1100011:
            push(rnd(), mk(9, z ^ f3,0,0,0,0, 2'b00,2'b10,2'b00,2'b01, 0,1,0,0));
         7'b1101111: begin
            push(rnd(), mk(10, 1,0,0,0,0, 2'b00,2'b01,2'b10,2'b00, 0,0,0,0));
            push(rnd(), mk(8, 0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,1,0,0));
         end
         7'b1100111: begin
            push(rnd(), mk(11, 1,0,0,0,0, 2'b10,2'b10,2'b01,2'b00, 0,0,0,0));
            push(rnd(), mk(12, 0,0,0,0,0, 2'b00,2'b01,2'b10,2'b00, 0,0,0,0));
            push(rnd(), mk(8, 0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,1,0,0));
         end
         default: begin
            if (o == 7'b1000100) begin
               for (int i = 0; i < stick; i++) push(rnd(), mk(13, 0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,1,0));
            end else if (trap) begin
               for (int i = 0; i < stick; i++) push(rnd(), mk(14, 0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,1));
            end
         end
      endcase
   endtask

   task automatic check(input logic [22:0] exp);
      logic [22:0] obs;
      obs = sel ? outB : outA;
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s t=%0t: observed=%h expected=%h", tag, $time, obs, exp);
      end
   endtask

   // Reset values: FETCH outputs with every enable/strobe low
   task automatic chk_reset();
      g_op = op;
      check(mk(0, 0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0,0,0,0));
   endtask

   // Replay n queued cycles; entered and left just after a rising edge
   task automatic play_n(input int n);
      logic [32:0] e;
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         op = e[32:26]; funct3_0 = e[25]; zero = e[24]; mem_ready = e[23];
         @(negedge clk);
         check(e[22:0]);
         @(posedge clk); #1;
      end
   endtask

   task automatic play_all();
      play_n(exp_q.size());
   endtask

   function automatic logic [6:0] rand_illegal();
      logic [6:0] o;
      do o = 7'($urandom_range(0, 127)); while (is_legal(o));
      rand_illegal = o;
   endfunction

   initial begin
      legal_ops[0] = 7'b0000011; legal_ops[1] = 7'b0100011; legal_ops[2] = 7'b0110011;
      legal_ops[3] = 7'b0010011; legal_ops[4] = 7'b1100011; legal_ops[5] = 7'b1101111;
      legal_ops[6] = 7'b1100111;
      resetA = 1'b0; resetB = 1'b0; op = 7'b0110011; funct3_0 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
      sel = 1'b0;

      tag = "reset_A";
      #12; chk_reset();
      @(posedge clk); #1; resetA = 1'b1;

      tag = "rtype_x2";
      gen_instr(7'b0110011, 0, 0, 0, 0, 1, 1, 0);
      gen_instr(7'b0110011, 0, 0, 0, 0, 1, 1, 0);
      play_all();

      tag = "bne_taken_then_not";
      gen_instr(7'b1100011, 1, 0, 0, 0, 1, 1, 0);
      gen_instr(7'b1100011, 1, 1, 0, 0, 1, 1, 0);
      gen_instr(7'b1100011, 0, 1, 0, 0, 1, 1, 0);
      play_all();

      tag = "lw_wait_2_3";
      gen_instr(7'b0000011, 0, 0, 2, 3, 1, 1, 0);
      play_all();

      tag = "sw_wait2_jalr";
      gen_instr(7'b0100011, 0, 0, 0, 2, 1, 1, 0);
      gen_instr(7'b1100111, 0, 0, 0, 0, 1, 1, 0);
      gen_instr(7'b1101111, 0, 0, 1, 0, 1, 1, 0);
      play_all();

      tag = "random_hs";
      for (int i = 0; i < 30; i++)
         gen_instr(legal_ops[$urandom_range(0, 6)], rnd(), rnd(),
                   $urandom_range(0, 3), $urandom_range(0, 3), 1, 1, 0);
      play_all();

      tag = "halt_sticky";
      gen_instr(7'b1000100, 0, 0, 0, 0, 1, 1, 100);
      play_all();
      tag = "reset_in_halt";
      #2 resetA = 1'b0;
      #1 chk_reset();
      @(posedge clk); #1; resetA = 1'b1;
      tag = "fetch_after_halt";
      gen_instr(7'b0010011, 0, 0, 0, 0, 1, 1, 0);
      play_all();

      tag = "trap_sticky";
      gen_instr(rand_illegal(), 0, 0, 1, 0, 1, 1, 20);
      play_all();
      tag = "reset_in_trap";
      #2 resetA = 1'b0;
      #1 chk_reset();
      @(posedge clk); #1; resetA = 1'b1;

      tag = "sw_memwrite_hold";
      gen_instr(7'b0100011, 0, 0, 1, 3, 1, 1, 0);
      play_n(5);
      mem_ready = 1'b0;
      #1 check(mk(5, 0,1,1,0,1, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0));
      tag = "reset_in_memwrite";
      #1 resetA = 1'b0;
      #1 chk_reset();
      exp_q.delete();
      @(posedge clk); #1; resetA = 1'b1;
      tag = "fetch_after_memwrite_reset";
      gen_instr(7'b0110011, 0, 0, 0, 0, 1, 1, 0);
      play_all();

      // second instance: memory always ready, unknown opcodes run as NOPs
      resetA = 1'b0;
      sel = 1'b1;
      tag = "reset_B";
      @(negedge clk); chk_reset();
      @(posedge clk); #1; resetB = 1'b1;

      tag = "illegal_nop";
      gen_instr(7'b1111111, 0, 0, 0, 0, 0, 0, 0);
      gen_instr(7'b0110011, 0, 0, 0, 0, 0, 0, 0);
      play_all();

      tag = "random_nohs";
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 5) == 0)
            gen_instr(rand_illegal(), rnd(), rnd(), 0, 0, 0, 0, 0);
         else
            gen_instr(legal_ops[$urandom_range(0, 6)], rnd(), rnd(), 0, 0, 0, 0, 0);
      end
      play_all();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
